// File: rtl/ysyx_041461_trap_sequencer_if.sv
// Bundle of signals between the trap sequencer, the writeback stage (trap code
// and CSRs), ID (interrupt tagging) and IF (redirect handshake).
interface ysyx_041461_trap_sequencer_if #(
    parameter int PC_W = 64
);
    logic            wb_valid;
    logic [3:0]      wb_trap;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic            mip_mtip;
    logic [PC_W-1:0] mtvec;
    logic [PC_W-1:0] mepc;
    logic            irq_ack;
    logic            if_ready;
    logic            flush;
    logic            irq_req;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            trap_busy;
    logic            trap_commit;
    logic            protocol_err;

    // Sequencer side.
    modport master (
        input  wb_valid, wb_trap, mstatus_mie, mie_mtie, mip_mtip,
        input  mtvec, mepc, irq_ack, if_ready,
        output flush, irq_req, redirect_valid, redirect_pc,
        output trap_busy, trap_commit, protocol_err
    );

    // Pipeline / CSR side.
    modport slave (
        output wb_valid, wb_trap, mstatus_mie, mie_mtie, mip_mtip,
        output mtvec, mepc, irq_ack, if_ready,
        input  flush, irq_req, redirect_valid, redirect_pc,
        input  trap_busy, trap_commit, protocol_err
    );
endinterface

// File: rtl/ysyx_041461_trap_sequencer.sv
// Trap sequencer: turns a writeback-stage trap (or a pending timer interrupt)
// into a timed pipeline flush followed by an IF redirect handshake.
package ysyx_041461_trap_pkg;
    localparam logic [3:0] TRAP_NOP        = 4'h0;
    localparam logic [3:0] ID_ECALL        = 4'h1;
    localparam logic [3:0] ID_EBREAK       = 4'h2;
    localparam logic [3:0] ID_MRET         = 4'h3;
    localparam logic [3:0] ID_ILLEGAL_INST = 4'h4;
    localparam logic [3:0] TIMER_INTERRUPT = 4'h7;
endpackage

module ysyx_041461_trap_sequencer
    import ysyx_041461_trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int PC_W         = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_041461_trap_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRQ_REQ,
        ST_IRQ_INFLIGHT,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [PC_W-1:0] trap_target;
    logic            commit_q, commit_d;
    logic            err_q;
    logic            irq_cond;
    logic            trap_ev;
    logic            busy;

    assign irq_cond = bus.mstatus_mie & bus.mie_mtie & bus.mip_mtip;
    assign trap_ev  = bus.wb_valid & (bus.wb_trap != TRAP_NOP);
    assign busy     = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT);

    // Redirect target for the trap currently presented by WB.
    always_comb begin
        trap_target = {bus.mtvec[PC_W-1:2], 2'b00};
        if (bus.wb_trap == ID_MRET) begin
            trap_target = bus.mepc;
        end else if (bus.wb_trap == TIMER_INTERRUPT && bus.mtvec[1:0] == 2'b01) begin
            // Vectored mode: base + 4 * cause, cause 7 for the machine timer.
            trap_target = {bus.mtvec[PC_W-1:2], 2'b00} + PC_W'(28);
        end
    end

    // Next-state, flush counter, target latch and commit pulse.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        commit_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_ev) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = trap_target;
                end else if (irq_cond) begin
                    state_d = ST_IRQ_REQ;
                end
            end
            ST_IRQ_REQ: begin
                if (trap_ev) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = trap_target;
                end else if (bus.irq_ack) begin
                    state_d = ST_IRQ_INFLIGHT;
                end else if (!irq_cond) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IRQ_INFLIGHT: begin
                // The tagged instruction traps even if irq_cond has since dropped.
                if (trap_ev) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = trap_target;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (bus.if_ready) begin
                    state_d  = ST_IDLE;
                    commit_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight trap.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            commit_q <= commit_d;
        end
    end

    // Sticky protocol error: WB must hold while the sequencer is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (trap_ev && busy) begin
            err_q <= 1'b1;
        end
    end

    assign bus.flush          = (state_q == ST_FLUSH);
    assign bus.irq_req        = (state_q == ST_IRQ_REQ);
    assign bus.redirect_valid = (state_q == ST_REDIRECT);
    assign bus.redirect_pc    = target_q;
    assign bus.trap_busy      = busy;
    assign bus.trap_commit    = commit_q;
    assign bus.protocol_err   = err_q;
endmodule

// File: tb/tb_ysyx_041461_trap_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model.
module tb_ysyx_041461_trap_sequencer;
    import ysyx_041461_trap_pkg::*;

    localparam int FC   = 1;
    localparam int PC_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_041461_trap_sequencer_if #(.PC_W(PC_W)) bus ();

    ysyx_041461_trap_sequencer #(.FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining flush cycles, pending redirect, irq phase flags.
    int          m_flush_left;
    bit          m_redir;
    bit          m_asked;
    bit          m_taken;
    bit          m_commit;
    bit          m_err;
    logic [63:0] m_pc;

    function automatic logic [63:0] expected_target(input logic [3:0] code,
                                                    input logic [63:0] tvec,
                                                    input logic [63:0] epc);
        logic [63:0] base;
        base = tvec & ~64'h3;
        if (code == ID_MRET) return epc;
        if (code == TIMER_INTERRUPT && tvec[1:0] == 2'b01) return base + 64'd7 * 64'd4;
        return base;
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_redir      = 0;
        m_asked      = 0;
        m_taken      = 0;
        m_commit     = 0;
        m_err        = 0;
        m_pc         = '0;
    endtask

    task automatic model_step();
        bit trap, cond;
        trap = bus.wb_valid && (bus.wb_trap != TRAP_NOP);
        cond = bus.mstatus_mie && bus.mie_mtie && bus.mip_mtip;
        m_commit = 0;
        if (m_flush_left > 0 || m_redir) begin
            if (trap) m_err = 1;
            if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_redir = 1;
            end else if (bus.if_ready) begin
                m_redir  = 0;
                m_commit = 1;
            end
        end else if (trap) begin
            m_pc         = expected_target(bus.wb_trap, bus.mtvec, bus.mepc);
            m_flush_left = FC;
            m_asked      = 0;
            m_taken      = 0;
        end else if (m_asked) begin
            if (bus.irq_ack) begin
                m_asked = 0;
                m_taken = 1;
            end else if (!cond) begin
                m_asked = 0;
            end
        end else if (!m_taken && cond) begin
            m_asked = 1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_flush"},  64'(bus.flush),          64'(m_flush_left > 0));
        check({tag, "_irq"},    64'(bus.irq_req),        64'(m_asked));
        check({tag, "_rv"},     64'(bus.redirect_valid), 64'(m_redir));
        check({tag, "_pc"},     bus.redirect_pc,         m_pc);
        check({tag, "_busy"},   64'(bus.trap_busy),      64'(m_flush_left > 0 || m_redir));
        check({tag, "_commit"}, 64'(bus.trap_commit),    64'(m_commit));
        check({tag, "_err"},    64'(bus.protocol_err),   64'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    task automatic clear_trap();
        bus.wb_valid = 1'b0;
        bus.wb_trap  = TRAP_NOP;
    endtask

    initial begin
        rst             = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_trap     = TRAP_NOP;
        bus.mstatus_mie = 1'b0;
        bus.mie_mtie    = 1'b0;
        bus.mip_mtip    = 1'b0;
        bus.mtvec       = '0;
        bus.mepc        = '0;
        bus.irq_ack     = 1'b0;
        bus.if_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_pc", bus.redirect_pc, 64'h0);
        rst = 1'b0;

        // ECALL: one flush cycle, redirect held until IF accepts.
        bus.mtvec = 64'h8000_0100;
        bus.mepc  = 64'h0000_1234;
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_ECALL;
        step("t1_take");
        check("t1_flush", 64'(bus.flush), 64'h1);
        clear_trap();
        step("t1_redir");
        check("t1_pc", bus.redirect_pc, 64'h8000_0100);
        repeat (3) begin
            step("t1_hold");
            check("t1_hold_rv", 64'(bus.redirect_valid), 64'h1);
        end
        bus.if_ready = 1'b1;
        step("t1_accept");
        check("t1_commit", 64'(bus.trap_commit), 64'h1);
        bus.if_ready = 1'b0;
        step("t1_idle");

        // MRET: target is mepc, mtvec ignored.
        bus.mepc  = 64'h8000_0A04;
        bus.mtvec = 64'h9000_0000;
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_MRET;
        step("t2_take");
        clear_trap();
        step("t2_redir");
        check("t2_pc", bus.redirect_pc, 64'h8000_0A04);
        bus.if_ready = 1'b1;
        step("t2_accept");
        bus.if_ready = 1'b0;
        step("t2_idle");

        // Vectored timer interrupt.
        bus.mtvec       = 64'h8000_0001;
        bus.mstatus_mie = 1'b1;
        bus.mie_mtie    = 1'b1;
        bus.mip_mtip    = 1'b1;
        step("t3_req");
        check("t3_irq_req", 64'(bus.irq_req), 64'h1);
        bus.irq_ack = 1'b1;
        step("t3_ack");
        check("t3_irq_drop", 64'(bus.irq_req), 64'h0);
        bus.irq_ack  = 1'b0;
        bus.mip_mtip = 1'b0;
        step("t3_inflight");
        bus.wb_valid = 1'b1;
        bus.wb_trap  = TIMER_INTERRUPT;
        step("t3_take");
        clear_trap();
        step("t3_redir");
        check("t3_pc", bus.redirect_pc, 64'h8000_001C);
        bus.if_ready = 1'b1;
        step("t3_accept");
        bus.if_ready = 1'b0;
        step("t3_idle");

        // Withdrawal before acknowledge.
        bus.mip_mtip = 1'b1;
        step("t4_req");
        step("t4_req2");
        bus.mip_mtip = 1'b0;
        step("t4_withdraw");
        check("t4_irq", 64'(bus.irq_req), 64'h0);
        step("t4_idle");
        check("t4_noflush", 64'(bus.flush), 64'h0);

        // Trap collides with an outstanding interrupt request.
        bus.mtvec    = 64'h8000_0200;
        bus.mip_mtip = 1'b1;
        step("t5_req");
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_ILLEGAL_INST;
        step("t5_take");
        check("t5_irq_drop", 64'(bus.irq_req), 64'h0);
        clear_trap();
        step("t5_redir");
        check("t5_pc", bus.redirect_pc, 64'h8000_0200);
        bus.if_ready = 1'b1;
        step("t5_accept");
        bus.if_ready = 1'b0;
        step("t5_rereq");
        check("t5_irq_again", 64'(bus.irq_req), 64'h1);
        bus.mip_mtip = 1'b0;
        step("t5_withdraw");

        // Trap while busy, then reset in the middle of a flush.
        bus.mtvec    = 64'h8000_0300;
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_ECALL;
        step("t6_take");
        clear_trap();
        step("t6_redir");
        bus.mepc     = 64'h8000_0F00;
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_MRET;
        step("t6_violate");
        check("t6_err", 64'(bus.protocol_err), 64'h1);
        check("t6_pc_kept", bus.redirect_pc, 64'h8000_0300);
        clear_trap();
        bus.if_ready = 1'b1;
        step("t6_accept");
        bus.if_ready = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_trap  = ID_ECALL;
        step("t6_flush");
        clear_trap();
        pulse_reset("t6_rst");
        check("t6_err_cleared", 64'(bus.protocol_err), 64'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.wb_valid    = ($urandom_range(99) < 30);
            bus.wb_trap     = 4'($urandom_range(15));
            bus.mstatus_mie = ($urandom_range(99) < 70);
            bus.mie_mtie    = ($urandom_range(99) < 80);
            bus.mip_mtip    = ($urandom_range(99) < 60);
            bus.mtvec       = {32'($urandom), 32'($urandom)};
            bus.mepc        = {32'($urandom), 32'($urandom)};
            bus.irq_ack     = ($urandom_range(99) < 40);
            bus.if_ready    = ($urandom_range(99) < 50);
            step("rand");
            if ($urandom_range(499) == 0) pulse_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
